// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - runtime-programmable modulo-N up/down counter with wrap reporting
module mod_counter #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              up,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  mod_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap_toggle,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // One extra bit so that mod_val = 0 means 2^WIDTH and L = 2^WIDTH-1 fits.
  logic [WIDTH:0]   modulus;
  logic [WIDTH:0]   limit_ext;
  logic [WIDTH-1:0] limit;
  logic             step_wrap;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_next;

  // Effective limit, next stepped value and wrap detection for the current direction.
  always_comb begin
    modulus   = (mod_val == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_val};
    limit_ext = modulus - {{WIDTH{1'b0}}, 1'b1};
    limit     = limit_ext[WIDTH-1:0];
    step_wrap = 1'b0;
    step_next = count;
    if (up) begin
      // A count left above a freshly lowered limit also wraps to 0.
      if (count >= limit) begin
        step_next = '0;
        step_wrap = 1'b1;
      end else begin
        step_next = count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      if ((count == '0) || (count > limit)) begin
        step_next = limit;
        step_wrap = 1'b1;
      end else begin
        step_next = count - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
    // Out-of-range load values fall back to 0 rather than an illegal count.
    load_next = (load_val <= limit) ? load_val : '0;
  end

  // Count register with clear > load > step > hold priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_next;
    end else if (en) begin
      count <= step_next;
    end
  end

  // Wrap reporting: tc pulses with the wrapped value, toggle and counter record each wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc          <= 1'b0;
      wrap_toggle <= 1'b0;
      wrap_cnt    <= '0;
    end else if (!clear && !load && en && step_wrap) begin
      tc          <= 1'b1;
      wrap_toggle <= ~wrap_toggle;
      wrap_cnt    <= wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
    end else begin
      tc          <= 1'b0;
    end
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N counter with runtime-programmable modulus, up/down direction, synchronous clear/load and wrap reporting. It is the generalised successor to the team's fixed 3-bit adder-plus-comparator modulo counter that drives the LED bank. It also provides the terminal-count pulse and the wrap-toggle flag that the LED bank previously generated with a separate toggle flip-flop. It sits between the debounced button/clock-enable logic and the LED/display drivers.

## Interface

- WIDTH, 3, bit width of count, mod_val and load_val (legal 1..16)
- WRAP_W, 4, bit width of wrap_cnt (legal 1..16)

- clk  input  1  single clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock, no other clock domains
- en  input  1  count enable; one step per rising edge while high
- up  input  1  direction: 1 = increment, 0 = decrement (sampled only when en steps)
- clear  input  1  synchronous clear of count to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- mod_val  input  WIDTH  modulus; counts 0..M-1 with M = mod_val, except mod_val = 0 means M = 2^WIDTH
- count  output  WIDTH  current count, registered
- tc  output  1  registered one-cycle pulse, high in the cycle the wrapped value is first shown on count
- wrap_toggle  output  1  registered; inverts on every wrap
- wrap_cnt  output  WRAP_W  registered count of wraps, modulo 2^WRAP_W

## Operation

- Effective limit L = M-1, computed with WIDTH+1-bit arithmetic so that mod_val = 0 yields L = 2^WIDTH-1 without overflow.
- Priority on each rising edge: clear > load > en step > hold.
- clear: count <= 0; tc <= 0; wrap_toggle and wrap_cnt hold.
- load: count <= load_val if load_val <= L, else count <= 0. tc <= 0, no wrap event.
- en step, up = 1: if count >= L, then count <= 0 (wrap event); else count <= count+1.
- en step, up = 0: if count == 0 or count > L, then count <= L (wrap event); else count <= count-1.
- Wrap event: tc <= 1, wrap_toggle <= ~wrap_toggle, wrap_cnt <= wrap_cnt+1 (wraps 2^WRAP_W-1 -> 0 silently).
- Any edge without a wrap event: tc <= 0.
- en low with no clear or load: all registers hold; tc <= 0.
- mod_val changes take effect on the next edge. If count already exceeds the new L, the next up step wraps to 0 and the next down step goes to the new L. Both count as wrap events.
- mod_val = 1: count stays 0. Every enabled step is a wrap event, so tc stays high continuously while en = 1.
- Direction may change on any cycle. Only the sampled up value at a stepping edge matters.

## Timing

- Reset (reset_n low, asynchronous assert, synchronous-safe deassert expected upstream): count = 0, tc = 0, wrap_toggle = 0, wrap_cnt = 0.
- Reset mid-count forces all outputs to reset values immediately, without waiting for a clock edge. The first edge after deassertion is processed normally.
- Latency: count, tc, wrap_toggle and wrap_cnt all update on the same rising edge that samples en/clear/load; there are no combinational paths from inputs to outputs.
- tc is coincident with the wrapped count value and lasts exactly one cycle per wrap event.
- Throughput: one step per cycle; there are no stall cycles.

## Test plan

- Reset, then WIDTH = 3, mod_val = 6, en = 1, up = 1 for 14 cycles -> count sequence 1,2,3,4,5,0,1,2,3,4,5,0,1,2. tc high only with each 0. wrap_toggle 0->1->0. wrap_cnt = 2.
- mod_val = 0 (M = 8), up = 0 starting from reset -> count 7,6,...,0,7. tc on each 7. wrap_cnt increments on the first step.
- count = 5, mod_val = 6; set mod_val = 3 with up = 1 -> next count 0 with tc = 1. Repeat with up = 0 -> next count 2 with tc = 1.
- Same edge with clear = 1, load = 1, en = 1 -> count 0, tc 0. Next, load = 1, load_val = 7 with mod_val = 6 -> count 0. Then load_val = 4 -> count 4, no wrap event.
- mod_val = 1, en = 1 for 5 cycles -> count stays 0, tc high all 5 cycles, wrap_toggle alternates, wrap_cnt = 5. With WRAP_W = 2, wrap_cnt reads 1 after 5 wraps.
- Assert reset_n low between clock edges mid-count (count = 4, wrap_cnt = 3) -> all outputs 0 before the next edge. After release, counting resumes from 0.
